// File: rtl/fb_pkg.sv
// Shared frame-buffer types: 12-bit pixel, frame dimensions from the monitor
// macros (H_FRAME_HT / V_FRAME_HT, defaulting to 640x480) and the arbiter state enum.
`ifndef H_FRAME_HT
`define H_FRAME_HT 640
`endif
`ifndef V_FRAME_HT
`define V_FRAME_HT 480
`endif

package fb_pkg;
  localparam int PIXEL_W    = 12;
  localparam int FB_H_FRAME = `H_FRAME_HT;
  localparam int FB_V_FRAME = `V_FRAME_HT;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: first active request at or after the pointer,
// wrapping; the pointer moves past the winner whenever advance is high.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] grant_idx_s;

  // scan requesters starting at the pointer, first active one wins
  always_comb begin
    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] idx_s;
    logic             found_s;
    logic             hit_s;
    grant       = '0;
    grant_idx_s = '0;
    sum_s       = '0;
    idx_s       = '0;
    found_s     = 1'b0;
    hit_s       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, ptr_r} + (IDX_W+1)'(k);
      sum_s = (sum_s >= (IDX_W+1)'(NUM_REQ)) ? sum_s - (IDX_W+1)'(NUM_REQ) : sum_s;
      idx_s = sum_s[IDX_W-1:0];
      hit_s = req[idx_s] & ~found_s;
      grant[idx_s] = hit_s;
      grant_idx_s  = hit_s ? idx_s : grant_idx_s;
      found_s      = found_s | hit_s;
    end
  end

  // pointer register: one past the last winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= (grant_idx_s == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx_s + IDX_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter with a built-in full-frame clear sweep.
// Optional macro FB_ARB_VBLANK_ONLY_EN restricts all writes to vblank=1 cycles.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int H_FRAME = FB_H_FRAME,
  parameter int V_FRAME = FB_V_FRAME,
  parameter int COL_W   = $clog2(H_FRAME),
  parameter int ROW_W   = $clog2(V_FRAME)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ROW_W-1:0]   req_row,
  input  logic [NUM_REQ*COL_W-1:0]   req_col,
  input  logic [NUM_REQ*PIXEL_W-1:0] req_pixel,
  input  logic                       clear_start,
  input  logic [PIXEL_W-1:0]         clear_color,
  output logic                       clear_busy,
  input  logic                       vblank,
  output logic                       fb_we,
  output logic [ROW_W-1:0]           fb_row,
  output logic [COL_W-1:0]           fb_col,
  output logic [PIXEL_W-1:0]         fb_pixel,
  output logic [15:0]                drop_count
);
  fb_state_e            state_r, state_next_s;
  logic [NUM_REQ-1:0]   arb_req_s, grant_s;
  logic                 vb_ok_s, clear_go_s, clr_issue_s, clr_last_s, xfer_s, in_range_s;
  logic [ROW_W-1:0]     sel_row_s, cur_row_s, clr_row_r, clr_row_next_s, fb_row_r;
  logic [COL_W-1:0]     sel_col_s, cur_col_s, clr_col_r, clr_col_next_s, fb_col_r;
  logic [PIXEL_W-1:0]   sel_pixel_s;
  pixel_t               cur_color_s, clr_color_r, fb_pixel_r;
  logic                 fb_we_r, clear_busy_r;
  logic [15:0]          drop_count_r;

`ifdef FB_ARB_VBLANK_ONLY_EN
  assign vb_ok_s = vblank;
`else
  logic unused_vblank_s;
  assign vb_ok_s         = 1'b1;
  assign unused_vblank_s = vblank;
`endif

  // a clear request pre-empts every requester in the same cycle
  assign clear_go_s = (state_r == ARB) && clear_start;
  assign arb_req_s  = (rst_n && (state_r == ARB) && !clear_start && vb_ok_s) ? req_valid : '0;
  assign req_ready  = grant_s;
  assign xfer_s     = |grant_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req_s),
    .advance (xfer_s),
    .grant   (grant_s)
  );

  // select the granted requester's fields
  always_comb begin
    sel_row_s   = '0;
    sel_col_s   = '0;
    sel_pixel_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_row_s   = sel_row_s   | (req_row[i*ROW_W +: ROW_W]       & {ROW_W{grant_s[i]}});
      sel_col_s   = sel_col_s   | (req_col[i*COL_W +: COL_W]       & {COL_W{grant_s[i]}});
      sel_pixel_s = sel_pixel_s | (req_pixel[i*PIXEL_W +: PIXEL_W] & {PIXEL_W{grant_s[i]}});
    end
    in_range_s = (int'(sel_row_s) < V_FRAME) && (int'(sel_col_s) < H_FRAME);
  end

  // next state and sweep position; the start cycle already issues pixel (0,0)
  always_comb begin
    state_next_s   = state_r;
    clr_row_next_s = clr_row_r;
    clr_col_next_s = clr_col_r;
    cur_row_s      = clr_row_r;
    cur_col_s      = clr_col_r;
    cur_color_s    = clr_color_r;
    clr_issue_s    = 1'b0;
    case (state_r)
      ARB: begin
        cur_row_s    = '0;
        cur_col_s    = '0;
        cur_color_s  = clear_color;
        clr_issue_s  = clear_start & vb_ok_s;
        state_next_s = clear_start ? CLEAR : ARB;
      end
      CLEAR: begin
        clr_issue_s  = vb_ok_s;
        state_next_s = CLEAR;
      end
      default: begin
        state_next_s = ARB;
      end
    endcase
    clr_last_s = (cur_row_s == ROW_W'(V_FRAME-1)) && (cur_col_s == COL_W'(H_FRAME-1));
    if (clr_issue_s) begin
      if (clr_last_s) begin
        state_next_s   = ARB;
        clr_row_next_s = '0;
        clr_col_next_s = '0;
      end else if (cur_col_s == COL_W'(H_FRAME-1)) begin
        clr_row_next_s = cur_row_s + ROW_W'(1);
        clr_col_next_s = '0;
      end else begin
        clr_row_next_s = cur_row_s;
        clr_col_next_s = cur_col_s + COL_W'(1);
      end
    end else if (clear_go_s) begin
      clr_row_next_s = '0;
      clr_col_next_s = '0;
    end else begin
      clr_row_next_s = clr_row_next_s;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB;
    end else begin
      state_r <= state_next_s;
    end
  end

  // sweep counters and latched clear colour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_row_r   <= '0;
      clr_col_r   <= '0;
      clr_color_r <= '0;
    end else begin
      clr_row_r   <= clr_row_next_s;
      clr_col_r   <= clr_col_next_s;
      clr_color_r <= clear_go_s ? pixel_t'(clear_color) : clr_color_r;
    end
  end

  // registered write port, busy flag and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we_r      <= 1'b0;
      fb_row_r     <= '0;
      fb_col_r     <= '0;
      fb_pixel_r   <= '0;
      clear_busy_r <= 1'b0;
      drop_count_r <= 16'h0000;
    end else begin
      clear_busy_r <= clear_go_s | (state_r == CLEAR);
      if (clr_issue_s) begin
        fb_we_r    <= 1'b1;
        fb_row_r   <= cur_row_s;
        fb_col_r   <= cur_col_s;
        fb_pixel_r <= cur_color_s;
      end else if (xfer_s && in_range_s) begin
        fb_we_r    <= 1'b1;
        fb_row_r   <= sel_row_s;
        fb_col_r   <= sel_col_s;
        fb_pixel_r <= pixel_t'(sel_pixel_s);
      end else begin
        fb_we_r <= 1'b0;
      end
      if (xfer_s && !in_range_s && (drop_count_r != 16'hFFFF)) begin
        drop_count_r <= drop_count_r + 16'd1;
      end else begin
        drop_count_r <= drop_count_r;
      end
    end
  end

  assign fb_we      = fb_we_r;
  assign fb_row     = fb_row_r;
  assign fb_col     = fb_col_r;
  assign fb_pixel   = fb_pixel_r;
  assign clear_busy = clear_busy_r;
  assign drop_count = drop_count_r;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed cases from the test plan plus
// randomized requests checked against a round-robin reference model.
module tb_fb_write_arbiter;
  localparam int NUM_REQ = 3;
  localparam int H       = 24;
  localparam int V       = 13;
  localparam int COL_W   = $clog2(H);
  localparam int ROW_W   = $clog2(V);
  localparam int NPIX    = H * V;

  logic                     clk, rst_n;
  logic [NUM_REQ-1:0]       req_valid, req_ready;
  logic [NUM_REQ*ROW_W-1:0] req_row;
  logic [NUM_REQ*COL_W-1:0] req_col;
  logic [NUM_REQ*12-1:0]    req_pixel;
  logic                     clear_start, clear_busy, vblank, fb_we;
  logic [11:0]              clear_color, fb_pixel;
  logic [ROW_W-1:0]         fb_row;
  logic [COL_W-1:0]         fb_col;
  logic [15:0]              drop_count;

  fb_write_arbiter #(.NUM_REQ(NUM_REQ), .H_FRAME(H), .V_FRAME(V), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_col(req_col), .req_pixel(req_pixel),
    .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
    .vblank(vblank), .fb_we(fb_we), .fb_row(fb_row), .fb_col(fb_col),
    .fb_pixel(fb_pixel), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  // reference model state
  int         m_ptr, m_drop, last_g;
  logic       exp_we;
  int         exp_row, exp_col;
  logic [11:0] exp_pix;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic vb_ok();
`ifdef FB_ARB_VBLANK_ONLY_EN
    return vblank;
`else
    return 1'b1;
`endif
  endfunction

  task automatic set_req(input int i, input logic v, input int row, input int col, input logic [11:0] pix);
    req_valid[i] = v;
    req_row[i*ROW_W +: ROW_W] = ROW_W'(row);
    req_col[i*COL_W +: COL_W] = COL_W'(col);
    req_pixel[i*12 +: 12]     = pix;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_drop = 0; last_g = -1;
    exp_we = 1'b0; exp_row = 0; exp_col = 0; exp_pix = 12'h000;
  endtask

  // one arbitration cycle, entered just after a negedge with inputs already driven
  task automatic arb_cycle(input string tag);
    int g, r, c, idx;
    logic [NUM_REQ-1:0] eg;
    #1;
    g = -1;
    eg = '0;
    if (vb_ok()) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    check_eq({tag, "_ready"}, 32'(req_ready), 32'(eg));
    exp_we = 1'b0;
    if (g >= 0) begin
      m_ptr = (g + 1) % NUM_REQ;
      r = int'(req_row[g*ROW_W +: ROW_W]);
      c = int'(req_col[g*COL_W +: COL_W]);
      if (r < V && c < H) begin
        exp_we = 1'b1; exp_row = r; exp_col = c; exp_pix = req_pixel[g*12 +: 12];
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    last_g = g;
    @(negedge clk);
    check_eq({tag, "_we"},   32'(fb_we), 32'(exp_we));
    check_eq({tag, "_row"},  32'(fb_row), 32'(exp_row));
    check_eq({tag, "_col"},  32'(fb_col), 32'(exp_col));
    check_eq({tag, "_pix"},  32'(fb_pixel), 32'(exp_pix));
    check_eq({tag, "_drop"}, 32'(drop_count), 32'(m_drop));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 1'b0; req_valid = '0; req_row = '0; req_col = '0; req_pixel = '0;
    clear_start = 1'b0; clear_color = 12'h000; vblank = 1'b1;
    model_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, i + 1, i + 2, 12'(12'h100 * (i + 1)));
    repeat (3) @(negedge clk);
    check_eq("rst_we", 32'(fb_we), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_busy", 32'(clear_busy), 32'd0);
    check_eq("rst_drop", 32'(drop_count), 32'd0);
    rst_n = 1'b1;

    // all three requesters continuously valid: 0,1,2,0,1,2
    for (int c = 0; c < 6; c++) begin
      #1 check_eq("rr_order", 32'(req_ready), 32'(1 << (c % 3)));
      arb_cycle("rr");
    end

    // single in-range write from requester 1
    req_valid = '0;
    set_req(1, 1'b1, 10, 20, 12'hF00);
    arb_cycle("req1");
    check_eq("req1_row", 32'(fb_row), 32'd10);
    check_eq("req1_pix", 32'(fb_pixel), 32'hF00);

    // out-of-range row is accepted but dropped, then saturation
    req_valid = '0;
    set_req(0, 1'b1, V, 5, 12'h0F0);
    arb_cycle("drop");
    check_eq("drop_one", 32'(drop_count), 32'd1);
    force dut.drop_count_r = 16'hFFFE;
    #1 release dut.drop_count_r;
    m_drop = 32'hFFFE;
    arb_cycle("sat1");
    arb_cycle("sat2");
    check_eq("drop_sat", 32'(drop_count), 32'hFFFF);

    // full clear while requester 0 is waiting
    req_valid = '0;
    set_req(0, 1'b1, 3, 4, 12'hABC);
    clear_start = 1'b1; clear_color = 12'h00F;
    #1 check_eq("clr_start_ready", 32'(req_ready), 32'd0);
    check_eq("clr_start_busy", 32'(clear_busy), 32'd0);
    @(negedge clk);
    clear_start = 1'b0; clear_color = 12'h777;
    check_eq("clr_first_we", 32'(fb_we), 32'd1);
    k = 0;
    for (int cyc = 0; cyc < NPIX + 20 && clear_busy; cyc++) begin
      if (fb_we) begin
        check_eq("clr_pix", 32'(fb_pixel), 32'h00F);
        check_eq("clr_row", 32'(fb_row), 32'(k / H));
        check_eq("clr_col", 32'(fb_col), 32'(k % H));
        k++;
      end
      if (k < NPIX) check_eq("clr_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    check_eq("clr_busy_end", 32'(clear_busy), 32'd0);
    check_eq("clr_count", 32'(k), 32'(NPIX));
    check_eq("clr_then_req0_we", 32'(fb_we), 32'd1);
    check_eq("clr_then_req0_pix", 32'(fb_pixel), 32'hABC);
    m_ptr = 1; exp_row = 3; exp_col = 4; exp_pix = 12'hABC;
    req_valid = '0;
    arb_cycle("post_clr");

    // reset in the middle of a clear sweep
    clear_start = 1'b1; clear_color = 12'h0A0;
    @(negedge clk);
    clear_start = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 200 && k < 100; cyc++) begin
      if (fb_we) k++;
      @(negedge clk);
    end
    check_eq("mid_clr_count", 32'(k), 32'd100);
    rst_n = 1'b0;
    #1 check_eq("mid_rst_we", 32'(fb_we), 32'd0);
    check_eq("mid_rst_busy", 32'(clear_busy), 32'd0);
    check_eq("mid_rst_row", 32'(fb_row), 32'd0);
    check_eq("mid_rst_pix", 32'(fb_pixel), 32'd0);
    check_eq("mid_rst_drop", 32'(drop_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 20; c++) begin
      arb_cycle("after_rst");
      check_eq("after_rst_busy", 32'(clear_busy), 32'd0);
    end

`ifdef FB_ARB_VBLANK_ONLY_EN
    // outside vblank nothing is written and the clear sweep stalls
    vblank = 1'b0;
    set_req(2, 1'b1, 1, 1, 12'h123);
    clear_start = 1'b1; clear_color = 12'h321;
    #1 check_eq("vb_start_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    clear_start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check_eq("vb_stall_we", 32'(fb_we), 32'd0);
      check_eq("vb_stall_busy", 32'(clear_busy), 32'd1);
      check_eq("vb_stall_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    vblank = 1'b1;
    @(negedge clk);
    check_eq("vb_resume_we", 32'(fb_we), 32'd1);
    check_eq("vb_resume_col", 32'(fb_col), 32'd0);
    check_eq("vb_resume_pix", 32'(fb_pixel), 32'h321);
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
`endif

    // randomized requests; a waiting requester keeps its fields stable
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || last_g == i)
          set_req(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 15), $urandom_range(0, 31), 12'($urandom));
      end
      vblank = 1'($urandom_range(0, 1));
      arb_cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
